// File: rtl/router_pkg.sv
// Shared constants and header-field helpers for the 1x3 router output buffers.
package router_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;

  // Destination code that no output port answers to.
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
    return hdr[7:2];
  endfunction

  function automatic logic [1:0] hdr_addr(input logic [7:0] hdr);
    return hdr[1:0];
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Register array for router_fifo: one synchronous write port, one asynchronous read port.
module router_fifo_mem #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_fifo.sv
// Per-destination output buffer: stores {header tag, byte}, drains with
// registered data_out and tracks packet length to blank the bus between packets.
module router_fifo
  import router_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic [6:0]      pkt_count;
  logic [WIDTH:0]  rd_entry;
  logic            wr_ok, rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // Both requests are judged against the pre-edge flags.
  assign wr_ok = write_enb && !full;
  assign rd_ok = read_enb && !empty;

  router_fifo_mem #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clock  (clock),
    .we     (wr_ok && !soft_reset),
    .wr_addr(wr_ptr[ADDR_W-1:0]),
    .wr_data({lfd_state, data_in}),
    .rd_addr(rd_ptr[ADDR_W-1:0]),
    .rd_data(rd_entry)
  );

  // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_count <= '0;
      data_out  <= '0;
    end else if (soft_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_count <= '0;
      data_out  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= rd_entry[WIDTH-1:0];
        // Header sets payload length plus one for the trailing parity byte.
        if (rd_entry[WIDTH])
          pkt_count <= {1'b0, hdr_len(rd_entry[7:0])} + 7'd1;
        else if (pkt_count != '0)
          pkt_count <= pkt_count - 7'd1;
      end else if (pkt_count == '0) begin
        data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_router_fifo;
  import router_pkg::*;

  logic       clock = 1'b0;
  logic       reset, soft_reset, write_enb, read_enb, lfd_state;
  logic [7:0] data_in, data_out;
  logic       full, empty;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of {tag, byte}, remaining packet bytes, expected bus value.
  logic [8:0] q[$];
  int         m_cnt;
  logic [7:0] m_dout;

  router_fifo dut (
    .clock     (clock),
    .reset     (reset),
    .soft_reset(soft_reset),
    .write_enb (write_enb),
    .read_enb  (read_enb),
    .lfd_state (lfd_state),
    .data_in   (data_in),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_cnt  = 0;
    m_dout = 8'h00;
  endtask

  task automatic check_outputs(input string where);
    check({where, ".data_out"}, data_out, m_dout);
    check({where, ".full"}, full, q.size() == 16);
    check({where, ".empty"}, empty, q.size() == 0);
  endtask

  // One clock: drive at negedge, update the model at the edge, sample 1ns later.
  task automatic cycle(input logic we, input logic re, input logic lfd,
                       input logic [7:0] din, input logic srst, input string where);
    logic       wr, rd;
    logic [8:0] e;
    @(negedge clock);
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    soft_reset = srst;
    @(posedge clock);
    if (srst) begin
      model_clear();
    end else begin
      wr = we && (q.size() < 16);
      rd = re && (q.size() > 0);
      if (rd) begin
        e      = q.pop_front();
        m_dout = e[7:0];
        if (e[8]) m_cnt = int'(e[7:2]) + 1;
        else if (m_cnt > 0) m_cnt--;
      end else if (m_cnt == 0) begin
        m_dout = 8'h00;
      end
      if (wr) q.push_back({lfd, din});
    end
    #1;
    check_outputs(where);
  endtask

  task automatic wr(input logic lfd, input logic [7:0] din, input string where);
    cycle(1'b1, 1'b0, lfd, din, 1'b0, where);
  endtask

  task automatic rd(input int n, input string where);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, where);
  endtask

  task automatic idle(input int n, input string where);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, where);
  endtask

  initial begin
    logic [7:0] d;
    logic       we, re, lfd, srst;

    reset = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00;
    model_clear();
    @(negedge clock);
    @(negedge clock);
    check_outputs("reset");
    reset = 1'b0;

    // Fill to capacity, overflow attempt, drain in order.
    for (int i = 1; i <= 16; i++) wr(1'b0, 8'(i), "fill");
    wr(1'b0, 8'hFF, "overflow");
    rd(16, "drain");
    idle(1, "drain_idle");

    // One complete packet: header 0x0D (length 3), three payloads, parity.
    wr(1'b1, 8'h0D, "pkt_wr");
    wr(1'b0, 8'hA1, "pkt_wr");
    wr(1'b0, 8'hA2, "pkt_wr");
    wr(1'b0, 8'hA3, "pkt_wr");
    wr(1'b0, 8'hAF, "pkt_wr");
    rd(5, "pkt_rd");
    idle(2, "pkt_after");

    // Zero-length and maximum-length headers.
    wr(1'b1, 8'h02, "len0");
    wr(1'b0, 8'h5A, "len0");
    rd(2, "len0_rd");
    idle(1, "len0_after");
    wr(1'b1, 8'hFC, "len63");
    for (int i = 0; i < 15; i++) wr(1'b0, 8'(8'h40 + i), "len63");
    rd(16, "len63_rd");
    idle(2, "len63_hold");

    // Wrap-around with concurrent read/write.
    model_clear();
    soft_reset = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "wrap_srst");
    for (int i = 0; i < 10; i++) wr(1'b0, 8'(8'h10 + i), "wrap_wr");
    rd(10, "wrap_rd");
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 8'(8'h60 + i), 1'b0, "wrap_rw");
    rd(2, "wrap_tail");

    // Simultaneous ops at full and at empty.
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'hC0 + i), "sim_fill");
    cycle(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0, "sim_full");
    rd(15, "sim_drain");
    idle(1, "sim_idle");
    cycle(1'b1, 1'b1, 1'b0, 8'h77, 1'b0, "sim_empty");
    rd(1, "sim_empty_rd");

    // Soft reset mid-packet together with a read.
    idle(1, "srst_pre");
    wr(1'b1, 8'h10, "srst_wr");
    for (int i = 0; i < 5; i++) wr(1'b0, 8'(8'h21 + i), "srst_wr");
    rd(2, "srst_rd");
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, "srst_pulse");
    wr(1'b1, 8'h05, "srst_pkt");
    wr(1'b0, 8'h33, "srst_pkt");
    wr(1'b0, 8'h3C, "srst_pkt");
    rd(3, "srst_pkt_rd");
    idle(1, "srst_pkt_after");

    // Asynchronous reset between edges while full.
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'h80 + i), "arst_fill");
    @(negedge clock);
    write_enb = 1'b0; read_enb = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst.empty", empty, 1'b1);
    check("arst.full", full, 1'b0);
    model_clear();
    check("arst.data_out", data_out, m_dout);
    @(negedge clock);
    reset = 1'b0;
    wr(1'b1, 8'h01, "arst_after");
    wr(1'b0, 8'h99, "arst_after");
    rd(2, "arst_after_rd");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      we   = $urandom_range(0, 99) < 55;
      re   = $urandom_range(0, 99) < 50;
      srst = $urandom_range(0, 99) < 2;
      lfd  = $urandom_range(0, 99) < 15;
      d    = 8'($urandom);
      if (lfd) begin
        while (hdr_addr(d) == ADDR_INVALID) d = 8'($urandom);
      end
      cycle(we, re, lfd, d, srst, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
